// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: quiz-buzzer arbiter. Each player's raw button is
// synchronised, debounced and turned into a one-cycle press event. A round is
// opened by arm; the first eligible press is captured together with that
// player's switch value and held until the consumer acknowledges it. Presses
// made before a round opens lock that player out until the round is closed.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_n        raw active-low buttons, bit i = player i
//   sw_in        player switches, player i at [i*SW_WIDTH +: SW_WIDTH]
//   arm          one-cycle pulse, opens a round (IDLE only)
//   ack          one-cycle pulse, closes a round (CAPTURED only)
//   winner_valid high while a captured result is held
//   winner_id    index of the captured player
//   switchInput  captured switch value of the winner
//   armed        high while a round is open
//   lockout      per-player false-start flags
module buzzer_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int SW_WIDTH    = 8,
    parameter int DB_CYCLES   = 100000,
    parameter int RR_MODE     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PLAYERS-1:0]            btn_n,
    input  logic [NUM_PLAYERS*SW_WIDTH-1:0]   sw_in,
    input  logic                              arm,
    input  logic                              ack,
    output logic                              winner_valid,
    output logic [$clog2(NUM_PLAYERS)-1:0]    winner_id,
    output logic [SW_WIDTH-1:0]               switchInput,
    output logic                              armed,
    output logic [NUM_PLAYERS-1:0]            lockout
);

    localparam int ID_W  = $clog2(NUM_PLAYERS);
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_t;

    state_t                 state, state_next;
    logic [NUM_PLAYERS-1:0] sync1, sync2;
    logic [NUM_PLAYERS-1:0] db_level, db_level_d;
    logic [CNT_W-1:0]       db_cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] press_evt, eligible;
    logic [ID_W-1:0]        pick_fixed, pick_rr, pick, last_winner;
    logic                   capture, close_round;

    // Two-flop synchroniser; idle level is released (1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Debouncer: level follows the synchronised input only after it has
    // disagreed for DB_CYCLES consecutive cycles; agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level   <= '1;
            db_level_d <= '1;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) db_cnt[i] <= '0;
        end else begin
            db_level_d <= db_level;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (sync2[i] != db_level[i]) begin
                    if (db_cnt[i] == CNT_MAX) begin
                        db_level[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press = debounced high-to-low transition only.
    always_comb press_evt = db_level_d & ~db_level;
    always_comb eligible  = press_evt & ~lockout;

    // Winner selection: fixed lowest index, or first index above the previous
    // winner with wrap-around.
    always_comb begin
        int unsigned idx;
        logic        found;
        pick_fixed = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) pick_fixed = ID_W'(i);
        end
        pick_rr = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
            idx = int'(last_winner) + k;
            if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
            if (!found && eligible[idx]) begin
                pick_rr = ID_W'(idx);
                found   = 1'b1;
            end
        end
        pick = (RR_MODE != 0) ? pick_rr : pick_fixed;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        close_round = 1'b0;
        case (state)
            IDLE:     if (arm) state_next = ARMED;
            ARMED:    if (|eligible) begin
                          state_next = CAPTURED;
                          capture    = 1'b1;
                      end
            CAPTURED: if (ack) begin
                          state_next  = IDLE;
                          close_round = 1'b1;
                      end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockout     <= '0;
            winner_id   <= '0;
            switchInput <= '0;
            last_winner <= ID_W'(NUM_PLAYERS - 1);
        end else begin
            // False starts are recorded in IDLE even on the arm cycle.
            if (state == IDLE)    lockout <= lockout | press_evt;
            else if (close_round) lockout <= '0;
            if (capture) begin
                winner_id   <= pick;
                switchInput <= sw_in[int'(pick)*SW_WIDTH +: SW_WIDTH];
                last_winner <= pick;
            end
        end
    end

    always_comb winner_valid = (state == CAPTURED);
    always_comb armed        = (state == ARMED);

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, number of player channels (2..16).
REQ-002 SHALL have parameter SW_WIDTH, default 8, switch bits per player.
REQ-003 SHALL have parameter DB_CYCLES, default 100000, debounce stability count in clk cycles (>=2).
REQ-004 SHALL have parameter RR_MODE, default 0; 0 = fixed lowest-index priority, 1 = rotating priority.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk input 1, system clock; rst input 1, asynchronous active-low reset.
REQ-006 SHALL have btn_n input NUM_PLAYERS, raw asynchronous buttons, active-low, bit i = player i.
REQ-007 SHALL have sw_in input NUM_PLAYERS*SW_WIDTH, player i switches at bits [i*SW_WIDTH +: SW_WIDTH].
REQ-008 SHALL have arm input 1, single-cycle pulse that opens a round.
REQ-009 SHALL have ack input 1, single-cycle pulse from the consumer that closes a round.
REQ-010 SHALL have winner_valid output 1, high while a captured result is held.
REQ-011 SHALL have winner_id output clog2(NUM_PLAYERS), index of the captured player.
REQ-012 SHALL have switchInput output SW_WIDTH, captured switch value of the winner.
REQ-013 SHALL have armed output 1, high while the state is ARMED.
REQ-014 SHALL have lockout output NUM_PLAYERS, per-player false-start flags.

Function
REQ-015 SHALL pass each btn_n bit through a 2-flop synchroniser, then a per-player debouncer.
REQ-016 Debouncer SHALL change its level only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 SHALL generate press_evt[i] for one cycle on each debounced high-to-low transition; releases SHALL generate no event.
REQ-018 Latency raw btn_n low (held stable) -> winner_valid high SHALL be exactly DB_CYCLES+3 cycles when the block is ARMED.
REQ-019 State machine SHALL have states IDLE, ARMED, CAPTURED.
REQ-020 IDLE -> ARMED on arm; arm SHALL be ignored in ARMED and CAPTURED.
REQ-021 In IDLE, press_evt[i] SHALL set lockout[i] (false start).
REQ-022 In ARMED, eligible set = press_evt & ~lockout; if non-empty, SHALL go to CAPTURED next cycle with winner_id and switchInput latched from the same cycle's eligible set and sw_in.
REQ-023 Simultaneous eligible presses: RR_MODE=0 SHALL pick the lowest index; RR_MODE=1 SHALL pick the first index above the previous winner, wrapping from NUM_PLAYERS-1 to 0 (previous winner = NUM_PLAYERS-1 after reset).
REQ-024 Presses by locked-out players in ARMED SHALL be ignored; lockout bits SHALL hold unchanged in ARMED and CAPTURED.
REQ-025 A button already held when arm arrives SHALL NOT win until released and pressed again.
REQ-026 In CAPTURED, winner_valid, winner_id, switchInput SHALL hold stable; further presses ignored.
REQ-027 CAPTURED -> IDLE on ack; lockout SHALL clear to 0 on that same edge; switchInput and winner_id SHALL retain their values, winner_valid SHALL fall.
REQ-028 ack in IDLE or ARMED SHALL be ignored.
REQ-029 arm and press_evt in the same IDLE cycle: the press SHALL set lockout and the state SHALL go to ARMED.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, winner_valid 0, winner_id 0, switchInput 0, armed 0, lockout 0, debounced levels 1 (released), debounce counters 0, synchronisers 1.
REQ-031 Reset asserted mid-round SHALL abandon the round; after release, a new arm is required.

Verification (DB_CYCLES=4, NUM_PLAYERS=4, SW_WIDTH=8)
REQ-032 arm; btn_n[2] low held, sw_in player2=8'hA5 -> winner_valid high 7 cycles after the btn edge, winner_id=2, switchInput=8'hA5; ack -> winner_valid 0, switchInput stays 8'hA5.
REQ-033 btn_n[1] low in IDLE -> lockout=4'b0010; release; arm; btn_n[1] press then btn_n[3] press -> winner_id=3; ack -> lockout=0.
REQ-034 RR_MODE=0, btn_n[3] and btn_n[1] fall same cycle while ARMED -> winner_id=1; RR_MODE=1 with previous winner 1, btn_n[0] and btn_n[3] together -> winner_id=3.
REQ-035 btn_n[0] toggling every 2 cycles for 20 cycles while ARMED -> no capture; then held low 4+ cycles -> capture winner_id=0.
REQ-036 rst low 1 cycle while CAPTURED -> all outputs 0 immediately, state IDLE; press without arm -> only lockout bit set, no capture.
